// File: rtl/serial_nibble_comp.sv
// Serial multi-nibble magnitude comparator: walks two WIDTH-bit operands MSB nibble first.
// Optional build macro SNC_EARLY_EXIT_EN: finish on the first differing nibble.
module serial_nibble_comp #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_eq_b,
    output logic             a_ls_b,
    output logic             a_gt_b,
    output logic             busy
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIB - 1);

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
        $error("serial_nibble_comp: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DEC_EQ = 2'd0,
        DEC_LS = 2'd1,
        DEC_GT = 2'd2
    } dec_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    dec_t             dec_q, dec_d;
    dec_t             dec_step;
    logic             valid_q, valid_d;
    logic [2:0]       flags_q, flags_d;
    logic             busy_q, busy_d;
    logic [3:0]       nib_a, nib_b;
    logic             last_step;

    // One-hot {eq, ls, gt} encoding of a decision
    function automatic logic [2:0] dec_flags(input dec_t d);
        logic [2:0] f;
        f = 3'b100;
        case (d)
            DEC_LS:  f = 3'b010;
            DEC_GT:  f = 3'b001;
            default: f = 3'b100;
        endcase
        return f;
    endfunction

    assign nib_a = 4'(a_q >> {idx_q, 2'b00});
    assign nib_b = 4'(b_q >> {idx_q, 2'b00});

    always_comb begin
        dec_step = dec_q;
        if ((dec_q == DEC_EQ) && (nib_a != nib_b)) begin
            dec_step = (nib_a < nib_b) ? DEC_LS : DEC_GT;
        end
    end

`ifdef SNC_EARLY_EXIT_EN
    assign last_step = (idx_q == '0) || (dec_step != DEC_EQ);
`else
    assign last_step = (idx_q == '0);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        dec_d   = dec_q;
        valid_d = valid_q;
        flags_d = flags_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_TOP;
                    dec_d   = DEC_EQ;
                    busy_d  = 1'b1;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                dec_d = dec_step;
                if (last_step) begin
                    valid_d = 1'b1;
                    flags_d = dec_flags(dec_step);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    flags_d = 3'b000;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                flags_d = 3'b000;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_TOP;
            a_q     <= '0;
            b_q     <= '0;
            dec_q   <= DEC_EQ;
            valid_q <= 1'b0;
            flags_q <= 3'b000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = valid_q;
    assign a_eq_b    = flags_q[2];
    assign a_ls_b    = flags_q[1];
    assign a_gt_b    = flags_q[0];
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_nibble_comp.sv
// Directed bench for serial_nibble_comp: arithmetic reference model plus per-cycle output checks.
module tb_serial_nibble_comp;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready, out_valid, a_eq_b, a_ls_b, a_gt_b, busy;

    int         errors = 0;
    int         checks = 0;
    logic [2:0] cur_exp = 3'b000;
    bit         cmp_en = 1'b0;

    serial_nibble_comp #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .a_eq_b(a_eq_b), .a_ls_b(a_ls_b), .a_gt_b(a_gt_b), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result as {eq, ls, gt} from plain unsigned comparison
    function automatic logic [2:0] model_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        if (x == y) return 3'b100;
        if (x < y)  return 3'b010;
        return 3'b001;
    endfunction

    // Clock edges from accept to out_valid
    function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SNC_EARLY_EXIT_EN
        for (int i = 0; i < int'(NIB); i++) begin
            int sh;
            sh = 4 * (int'(NIB) - 1 - i);
            if (((x >> sh) & 15) != ((y >> sh) & 15)) return i + 1;
        end
        return int'(NIB);
`else
        return int'(NIB);
`endif
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready_vs_busy", {31'b0, in_ready}, {31'b0, !busy});
            if (out_valid) chk("flags_model", {29'b0, a_eq_b, a_ls_b, a_gt_b}, {29'b0, cur_exp});
            else           chk("flags_idle", {29'b0, a_eq_b, a_ls_b, a_gt_b}, 32'd0);
        end
    end

    task automatic accept(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", {31'b0, in_ready}, 32'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cur_exp = model_flags(av, bv);
    endtask

    task automatic wait_result(input string name, input logic [WIDTH-1:0] av,
                               input logic [WIDTH-1:0] bv, input logic [2:0] lit);
        int lat;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        chk({name, "_latency"}, 32'(lat), 32'(model_lat(av, bv)));
        chk({name, "_flags"}, {29'b0, a_eq_b, a_ls_b, a_gt_b}, {29'b0, lit});
        chk({name, "_model"}, {29'b0, model_flags(av, bv)}, {29'b0, lit});
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        chk({name, "_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run(input string name, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic [2:0] lit);
        accept(av, bv);
        wait_result(name, av, bv, lit);
        release_result(name);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_flags", {29'b0, a_eq_b, a_ls_b, a_gt_b}, 32'd0);
        cmp_en = 1'b1;
        @(posedge clk); #1;

        run("t1_eq", 16'h1234, 16'h1234, 3'b100);
        run("t2_msb_gt", 16'h8000, 16'h7FFF, 3'b001);
        run("t3_lsb_ls", 16'h0001, 16'h0002, 3'b010);
        run("zeros_eq", 16'h0000, 16'h0000, 3'b100);
        run("ones_eq", 16'hFFFF, 16'hFFFF, 3'b100);
        run("mid_gt", 16'h12F4, 16'h1234, 3'b001);

        // Consumer stalls; stray in_valid pulses must be ignored
        out_ready = 1'b0;
        accept(16'hFFFF, 16'h0000);
        wait_result("t4_stall", 16'hFFFF, 16'h0000, 3'b001);
        for (int i = 0; i < 3; i++) begin
            a = 16'h0000;
            b = 16'h0001;
            in_valid = (i != 1);
            @(posedge clk); #1;
            chk("t4_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("t4_hold_ready", {31'b0, in_ready}, 32'd0);
            chk("t4_hold_busy", {31'b0, busy}, 32'd1);
        end
        in_valid = 1'b0;
        release_result("t4_stall");
        @(posedge clk); #1;
        chk("t4_no_stray_accept", {31'b0, busy}, 32'd0);

        // Reset during CMP aborts the transaction
        accept(16'h00F0, 16'h0F00);
        @(posedge clk); #1;
        chk("t5_in_cmp", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("t5_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("t5_rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("t5_no_result", {31'b0, out_valid}, 32'd0);
        end
        run("t5_after", 16'hABCD, 16'hABCD, 3'b100);

        // Back-to-back with in_valid held high
        a = 16'h0000;
        b = 16'hFFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        cur_exp = model_flags(16'h0000, 16'hFFFF);
        chk("t6_first_accept", {31'b0, busy}, 32'd1);
        wait_result("t6_first", 16'h0000, 16'hFFFF, 3'b010);
        a = 16'hFFFF;
        b = 16'h0000;
        @(posedge clk); #1;
        chk("t6_handshake_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_bubble_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        cur_exp = model_flags(16'hFFFF, 16'h0000);
        in_valid = 1'b0;
        chk("t6_second_accept", {31'b0, busy}, 32'd1);
        wait_result("t6_second", 16'hFFFF, 16'h0000, 3'b001);
        release_result("t6_second");

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
